// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
// Holds the RV32I load/store func3 encodings, the controller state enum,
// the word-transfer func3 driven on the memory port, and the fault
// classifier used at request accept time.
package lsu_pkg;

    localparam int NUM_LANES = 4;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [2:0] MEM_WORD_FUNC3 = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsuState_t;

    // Illegal encodings take priority over alignment; a faulted request
    // never touches memory.
    function automatic logic isFault(input logic       isStore,
                                     input logic [2:0] func3,
                                     input logic [1:0] offset);
        if (func3 == 3'b011 || func3 == 3'b110 || func3 == 3'b111) return 1'b1;
        if (isStore && func3[2])                                   return 1'b1;
        if (func3[1:0] == 2'b01 && offset[0])                      return 1'b1;
        if (func3[1:0] == 2'b10 && offset != 2'b00)                return 1'b1;
        return 1'b0;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: combinational byte-lane steering for the load/store unit.
//   func3      : RV32I load/store func3 of the captured request
//   offset     : byte offset addr[1:0]
//   word       : aligned memory word (read data)
//   storeData  : right-justified store data
//   loadData   : shifted and sign/zero-extended load result
//   mergedWord : word to write back; for SW this is storeData unchanged,
//                for SB/SH only the addressed lane(s) are replaced
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] storeData,
    output logic [31:0] loadData,
    output logic [31:0] mergedWord
);

    logic [31:0] shifted;
    logic [NUM_LANES-1:0][7:0] mergedLanes;

    assign shifted = word >> {offset, 3'b000};

    always_comb begin
        loadData = '0;
        case (func3)
            F3_LB:   loadData = {{24{shifted[7]}},  shifted[7:0]};
            F3_LH:   loadData = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   loadData = shifted;
            F3_LBU:  loadData = {24'b0, shifted[7:0]};
            F3_LHU:  loadData = {16'b0, shifted[15:0]};
            default: loadData = '0;
        endcase
    end

    // Each lane decides independently whether it takes store data or keeps
    // the old memory byte. func3[1:0] is the access size (00 byte, 01 half,
    // 10 word); size 11 only occurs on faulted requests, which never write.
    for (genvar lane = 0; lane < NUM_LANES; lane++) begin : gLane
        localparam logic [1:0] LANE_IDX = 2'(lane);
        logic       sel;
        logic [7:0] srcByte;

        always_comb begin
            sel     = 1'b1;
            srcByte = storeData[8*lane +: 8];
            case (func3[1:0])
                2'b00: begin
                    sel     = (offset == LANE_IDX);
                    srcByte = storeData[7:0];
                end
                2'b01: begin
                    sel     = (offset[1] == LANE_IDX[1]);
                    srcByte = storeData[8*(lane % 2) +: 8];
                end
                default: begin
                    sel     = 1'b1;
                    srcByte = storeData[8*lane +: 8];
                end
            endcase
        end

        assign mergedLanes[lane] = sel ? srcByte : word[8*lane +: 8];
    end

    assign mergedWord = mergedLanes;

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage initiator.
// Takes one load/store request at a time from execute and turns it into
// word-aligned transfers on the data-memory port. Sub-word stores are done
// as read-modify-write; loads are extracted and extended here. Misaligned
// or illegal requests and memory timeouts are reported in the response.
//   clock, reset        : clock, synchronous active-high reset
//   req_*               : request handshake and fields from execute
//   resp_*              : one-cycle response strobe, load data, fault flags
//   memory*             : word-aligned data-memory port
// All outputs are decoded from registered state and captured fields, and
// are forced to 0 while reset is high.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_store_data,
    output logic        resp_valid,
    output logic [31:0] resp_load_data,
    output logic        resp_misaligned,
    output logic        resp_timeout,
    output logic        memoryReadEnable,
    output logic        memoryWriteEnable,
    output logic [2:0]  memoryFunc3,
    output logic [31:0] memoryAddress,
    output logic [31:0] memoryWriteData,
    input  logic [31:0] memoryReadData,
    input  logic        memoryReady
);

    // The counter holds the number of stalled cycles already spent in the
    // current phase, so the last allowed cycle is at TIMEOUT_CYCLES-1.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsuState_t   state, nextState;
    logic        isStoreQ;
    logic [2:0]  func3Q;
    logic [31:0] addrQ;
    logic [31:0] storeDataQ;
    logic [31:0] wordQ;
    logic        misalignedQ;
    logic        timeoutQ;
    logic [7:0]  waitCnt;

    logic        accept;
    logic        waitExpired;
    logic        needsRmw;
    logic        inTransfer;
    logic [31:0] laneLoadData;
    logic [31:0] laneMerged;

    assign accept      = (state == IDLE) && req_valid;
    assign waitExpired = !memoryReady && (waitCnt == TIMEOUT_LAST);
    assign needsRmw    = isStoreQ && (func3Q != F3_SW);
    assign inTransfer  = (state == RD) || (state == WR);

    lsu_byte_lane uByteLane (
        .func3      (func3Q),
        .offset     (addrQ[1:0]),
        .word       (wordQ),
        .storeData  (storeDataQ),
        .loadData   (laneLoadData),
        .mergedWord (laneMerged)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState         = state;
        req_ready         = 1'b0;
        resp_valid        = 1'b0;
        resp_load_data    = '0;
        resp_misaligned   = 1'b0;
        resp_timeout      = 1'b0;
        memoryReadEnable  = 1'b0;
        memoryWriteEnable = 1'b0;
        memoryFunc3       = MEM_WORD_FUNC3;
        memoryAddress     = '0;
        memoryWriteData   = '0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (isFault(req_is_store, req_func3, req_address[1:0]))
                        nextState = RESP;
                    else if (req_is_store && req_func3 == F3_SW)
                        nextState = WR;
                    else
                        nextState = RD;
                end
            end
            RD: begin
                memoryReadEnable = 1'b1;
                memoryAddress    = {addrQ[31:2], 2'b00};
                if (memoryReady)      nextState = needsRmw ? WR : RESP;
                else if (waitExpired) nextState = RESP;
            end
            WR: begin
                memoryWriteEnable = 1'b1;
                memoryAddress     = {addrQ[31:2], 2'b00};
                memoryWriteData   = laneMerged;
                if (memoryReady || waitExpired) nextState = RESP;
            end
            RESP: begin
                resp_valid      = 1'b1;
                resp_misaligned = misalignedQ;
                resp_timeout    = timeoutQ;
                if (!isStoreQ && !misalignedQ && !timeoutQ)
                    resp_load_data = laneLoadData;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase

        // Reset silences the port, which also covers the undefined state
        // before the first reset edge.
        if (reset) begin
            req_ready         = 1'b0;
            resp_valid        = 1'b0;
            resp_load_data    = '0;
            resp_misaligned   = 1'b0;
            resp_timeout      = 1'b0;
            memoryReadEnable  = 1'b0;
            memoryWriteEnable = 1'b0;
            memoryFunc3       = '0;
            memoryAddress     = '0;
            memoryWriteData   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            isStoreQ    <= 1'b0;
            func3Q      <= '0;
            addrQ       <= '0;
            storeDataQ  <= '0;
            wordQ       <= '0;
            misalignedQ <= 1'b0;
            timeoutQ    <= 1'b0;
            waitCnt     <= '0;
        end else begin
            if (accept) begin
                isStoreQ    <= req_is_store;
                func3Q      <= req_func3;
                addrQ       <= req_address;
                storeDataQ  <= req_store_data;
                misalignedQ <= isFault(req_is_store, req_func3, req_address[1:0]);
                timeoutQ    <= 1'b0;
            end
            if (state == RD && memoryReady) wordQ <= memoryReadData;
            if (inTransfer && waitExpired)  timeoutQ <= 1'b1;

            // Any state change (including RD->WR) starts a fresh wait window.
            if (nextState != state)             waitCnt <= '0;
            else if (inTransfer && !memoryReady) waitCnt <= waitCnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit.
// A memory model with programmable per-phase stall answers the DUT; a
// reference model computes each response (data, flags, strobe counts,
// latency, write word) at issue time and a separate monitor compares.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_func3 = 3'b0;
    logic [31:0] req_address = 32'h0;
    logic [31:0] req_store_data = 32'h0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_load_data;
    logic        resp_misaligned;
    logic        resp_timeout;
    logic        memoryReadEnable;
    logic        memoryWriteEnable;
    logic [2:0]  memoryFunc3;
    logic [31:0] memoryAddress;
    logic [31:0] memoryWriteData;
    logic [31:0] memoryReadData;
    logic        memoryReady;

    always #5 clock = ~clock;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_is_store      (req_is_store),
        .req_func3         (req_func3),
        .req_address       (req_address),
        .req_store_data    (req_store_data),
        .resp_valid        (resp_valid),
        .resp_load_data    (resp_load_data),
        .resp_misaligned   (resp_misaligned),
        .resp_timeout      (resp_timeout),
        .memoryReadEnable  (memoryReadEnable),
        .memoryWriteEnable (memoryWriteEnable),
        .memoryFunc3       (memoryFunc3),
        .memoryAddress     (memoryAddress),
        .memoryWriteData   (memoryWriteData),
        .memoryReadData    (memoryReadData),
        .memoryReady       (memoryReady)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem    [1024];
    logic [31:0] refMem [1024];
    int stallRd  = 0;
    int stallWr  = 0;
    int phaseCnt = 0;
    int cycle    = 0;

    assign memoryReady = (memoryReadEnable || memoryWriteEnable) &&
                         (phaseCnt >= (memoryReadEnable ? stallRd : stallWr));
    assign memoryReadData = memoryReadEnable ? mem[memoryAddress[11:2]] : 32'h0;

    always @(posedge clock) begin
        cycle <= cycle + 1;
        if ((memoryReadEnable || memoryWriteEnable) && !memoryReady) phaseCnt <= phaseCnt + 1;
        else phaseCnt <= 0;
        if (memoryWriteEnable && memoryReady) mem[memoryAddress[11:2]] <= memoryWriteData;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        fault;
        logic        tmo;
        logic [31:0] data;
        logic [31:0] addr;
        logic [31:0] wData;
        logic        wrDone;
        int          rd;
        int          wr;
        int          delta;
        int          acceptCycle;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed arithmetic on refMem.
    function automatic exp_t predict(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] sd, input int sRd, input int sWr);
        exp_t e;
        int bytes, off;
        logic [31:0] w, shifted, mask;
        logic needRd, rdTo, wrTo;
        e.fault = 0; e.tmo = 0; e.data = 0; e.addr = a; e.wData = 0; e.wrDone = 0;
        e.rd = 0; e.wr = 0; e.delta = 0; e.acceptCycle = 0;
        off   = int'(a[1:0]);
        w     = refMem[a[11:2]];
        bytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        e.fault = (f3 == 3'd3) || (f3 > 3'd5) || (st && f3 >= 3'd4) || ((a % bytes) != 0);
        if (!e.fault) begin
            needRd = !st || (bytes < 4);
            rdTo   = needRd && (sRd >= TO);
            e.rd   = needRd ? ((sRd >= TO) ? TO : sRd + 1) : 0;
            wrTo   = st && !rdTo && (sWr >= TO);
            e.wr   = (st && !rdTo) ? ((sWr >= TO) ? TO : sWr + 1) : 0;
            e.tmo  = rdTo || wrTo;
            if (st) begin
                mask     = (bytes == 4) ? 32'hFFFF_FFFF : (bytes == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
                e.wData  = (w & ~(mask << (8 * off))) | ((sd & mask) << (8 * off));
                e.wrDone = !e.tmo;
                if (!e.tmo) refMem[a[11:2]] = e.wData;
            end else if (!e.tmo) begin
                shifted = w >> (8 * off);
                case (f3)
                    3'd0:    e.data = 32'($signed(shifted[7:0]));
                    3'd1:    e.data = 32'($signed(shifted[15:0]));
                    3'd4:    e.data = shifted & 32'hFF;
                    3'd5:    e.data = shifted & 32'hFFFF;
                    default: e.data = shifted;
                endcase
            end
        end
        e.delta = e.rd + e.wr;
        return e;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        int rdCnt, wrCnt;
        logic sawWr;
        logic [31:0] wrData;
        rdCnt = 0; wrCnt = 0; sawWr = 0; wrData = 0;
        forever begin
            @(negedge clock);
            #1;
            check("rw_exclusive", 32'(memoryReadEnable && memoryWriteEnable), 0);
            if (reset) begin
                check("reset_quiet", 32'(|{req_ready, resp_valid, resp_load_data, resp_misaligned,
                      resp_timeout, memoryReadEnable, memoryWriteEnable, memoryFunc3,
                      memoryAddress, memoryWriteData}), 0);
                rdCnt = 0; wrCnt = 0; sawWr = 0;
            end else begin
                check("mem_func3", 32'(memoryFunc3), 32'h2);
                if (!memoryReadEnable && !memoryWriteEnable)
                    check("bus_idle", memoryAddress | memoryWriteData, 0);
                else if (sbq.size() > 0)
                    check("mem_addr", memoryAddress, {sbq[0].addr[31:2], 2'b00});
                if (memoryReadEnable) rdCnt++;
                if (memoryWriteEnable) begin
                    wrCnt++;
                    if (memoryReady) begin sawWr = 1; wrData = memoryWriteData; end
                end
                if (resp_valid) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_resp", 32'(resp_valid), 0);
                    end else begin
                        e = sbq.pop_front();
                        check("resp_misaligned", 32'(resp_misaligned), 32'(e.fault));
                        check("resp_timeout", 32'(resp_timeout), 32'(e.tmo));
                        check("resp_load_data", resp_load_data, e.data);
                        check("latency", 32'(cycle - e.acceptCycle), 32'(e.delta));
                        check("rd_cycles", 32'(rdCnt), 32'(e.rd));
                        check("wr_cycles", 32'(wrCnt), 32'(e.wr));
                        check("wr_done", 32'(sawWr), 32'(e.wrDone));
                        if (e.wrDone) check("wr_data", wrData, e.wData);
                    end
                    rdCnt = 0; wrCnt = 0; sawWr = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic doReq(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input int sRd, input int sWr);
        exp_t e;
        int waitN;
        @(negedge clock);
        stallRd = sRd; stallWr = sWr;
        req_valid = 1; req_is_store = st; req_func3 = f3; req_address = a; req_store_data = sd;
        waitN = 0;
        while (!req_ready && waitN < 50) begin @(negedge clock); waitN++; end
        check("req_ready_wait", 32'(req_ready), 1);
        @(posedge clock);
        #1;
        req_valid = 0;
        e = predict(st, f3, a, sd, sRd, sWr);
        e.acceptCycle = cycle;
        sbq.push_back(e);
        waitN = 0;
        while (sbq.size() != 0 && waitN < 50) begin @(negedge clock); waitN++; end
        check("resp_wait", 32'(sbq.size()), 0);
    endtask

    initial begin
        logic [31:0] v;
        int waitN, r, sRd, sWr;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            if (i == 4) v = 32'h80FF_1234;
            if (i == 8) v = 32'h1122_3344;
            mem[i] <= v;
            refMem[i] = v;
        end

        reset = 1;
        repeat (3) @(negedge clock);
        reset = 0;
        #1;
        check("ready_after_reset", 32'(req_ready), 1);

        // directed cases
        doReq(0, 3'b010, 32'h10, 0, 0, 0);          // LW  -> 80FF1234
        doReq(0, 3'b000, 32'h13, 0, 0, 0);          // LB  -> FFFFFF80
        doReq(0, 3'b100, 32'h13, 0, 0, 0);          // LBU -> 00000080
        doReq(0, 3'b101, 32'h12, 0, 0, 0);          // LHU -> 000080FF
        doReq(0, 3'b001, 32'h12, 0, 0, 0);          // LH  -> FFFF80FF
        doReq(1, 3'b000, 32'h21, 32'hAB, 0, 0);     // SB RMW -> 1122AB44
        doReq(0, 3'b010, 32'h20, 0, 0, 0);          // read-back
        doReq(0, 3'b010, 32'h06, 0, 0, 0);          // misaligned LW
        doReq(1, 3'b001, 32'h05, 32'h1234, 0, 0);   // misaligned SH
        doReq(1, 3'b100, 32'h00, 32'h1, 0, 0);      // illegal store func3
        doReq(0, 3'b011, 32'h00, 0, 0, 0);          // illegal func3
        doReq(0, 3'b010, 32'h10, 0, 10, 0);         // read timeout
        doReq(0, 3'b010, 32'h10, 0, 2, 0);          // 2-cycle stall
        doReq(0, 3'b010, 32'h10, 0, 3, 0);          // last cycle before timeout
        doReq(1, 3'b010, 32'h40, 32'hDEAD_BEEF, 0, 9); // SW write timeout
        doReq(1, 3'b000, 32'h41, 32'h77, 9, 0);     // RMW read timeout, no write
        doReq(1, 3'b001, 32'h42, 32'hCAFE, 1, 2);   // SH RMW with stalls
        doReq(0, 3'b010, 32'h40, 0, 0, 0);

        // reset during the RD phase of an SB
        @(negedge clock);
        stallRd = 3; stallWr = 0;
        req_valid = 1; req_is_store = 1; req_func3 = 3'b000; req_address = 32'h31; req_store_data = 32'h55;
        waitN = 0;
        while (!req_ready && waitN < 50) begin @(negedge clock); waitN++; end
        check("rst_req_ready", 32'(req_ready), 1);
        @(posedge clock);
        #1;
        req_valid = 0;
        @(negedge clock);
        check("rst_rd_active", 32'(memoryReadEnable), 1);
        reset = 1;
        @(negedge clock);
        reset = 0;
        #1;
        check("rst_ready", 32'(req_ready), 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("rst_no_wr", 32'(memoryWriteEnable), 0);
            check("rst_no_resp", 32'(resp_valid), 0);
        end
        doReq(0, 3'b010, 32'h30, 0, 0, 0);          // word untouched by aborted SB

        // randomized traffic over a small address window
        for (int n = 0; n < 200; n++) begin
            r   = $urandom_range(0, 9);
            sRd = (r < 6) ? 0 : (r < 8) ? $urandom_range(1, 3) : $urandom_range(4, 6);
            r   = $urandom_range(0, 9);
            sWr = (r < 6) ? 0 : (r < 8) ? $urandom_range(1, 3) : $urandom_range(4, 6);
            doReq(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)),
                  $urandom, sRd, sWr);
        end

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage initiator that turns one load/store request from the execute stage into word-aligned transactions on the data-memory port. The data memory indexes words by address[11:2] and ignores byte offset, so byte lane alignment happens here. Sub-word stores are done as read-modify-write. Loads are shifted and sign/zero-extended here. The unit also detects misaligned accesses and memory timeouts, and returns one response per request.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles waiting for memoryReady before a transfer is aborted; range 1–255.

Ports (reset: synchronous, active-high; clock: clock):
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_is_store  in  1  1 = store, 0 = load
- req_func3  in  3  RV32I load/store func3
- req_address  in  32  byte address
- req_store_data  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response strobe
- resp_load_data  out  32  extended load result; 0 for stores and faults
- resp_misaligned  out  1  alignment fault or illegal func3; no memory access made
- resp_timeout  out  1  memory did not respond within TIMEOUT_CYCLES
- memoryReadEnable  out  1  memory read strobe
- memoryWriteEnable  out  1  memory write strobe
- memoryFunc3  out  3  always 3'b010 (word)
- memoryAddress  out  32  {addr[31:2], 2'b00}
- memoryWriteData  out  32  full word to write
- memoryReadData  in  32  word read data, valid while memoryReadEnable is high
- memoryReady  in  1  memory completes the transfer at this edge

## Operation
- FSM states: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, capture all request fields.
  - Fault check, in priority order:
    - func3 ∈ {011, 110, 111} → fault.
    - Store with func3 ∈ {100, 101} → fault.
    - Halfword access with addr[0] ≠ 0 → fault.
    - Word access with addr[1:0] ≠ 0 → fault.
  - Fault → RESP with resp_misaligned = 1.
  - Load, SB or SH → RD.
  - SW → WR.
- RD:
  - memoryReadEnable = 1.
  - When memoryReady is high, latch memoryReadData.
  - Load → RESP. SB/SH → WR, using a merged word: the target byte/halfword lane at offset addr[1:0] replaced with req_store_data[7:0] or [15:0].
- WR:
  - memoryWriteEnable = 1, memoryWriteData = full or merged word.
  - When memoryReady is high → RESP.
- Timeout:
  - A wait counter clears on entry to RD and to WR and increments each cycle memoryReady is low.
  - Reaching TIMEOUT_CYCLES → RESP with resp_timeout = 1. No write is issued after a timed-out RMW read.
- Load extraction:
  - word >> (8·addr[1:0]).
  - LB/LH: sign-extend bit 7/15. LBU/LHU: zero-extend. LW: unchanged.
- RESP:
  - resp_valid = 1 for exactly one cycle; no backpressure; → IDLE.
  - At most one of resp_misaligned and resp_timeout is 1.
- Bus hygiene:
  - memoryReadEnable and memoryWriteEnable are never high together.
  - memoryAddress and memoryWriteData are 0 outside RD/WR.

## Timing
- Reset:
  - State IDLE; counter 0.
  - All outputs 0, including req_ready, while reset is high.
  - req_ready = 1 from the first cycle after reset falls.
- Reset mid-operation: the transaction is abandoned and no response is produced. Enables are 0 in the cycle after the reset edge.
- Latency, counted from the accept edge E0, with memoryReady tied high:
  - Load or SW: strobe in cycle E0+1; resp_valid in cycle E0+2; next accept at E0+3.
  - SB/SH: RD in E0+1, WR in E0+2, resp_valid in E0+3.
  - Fault: resp_valid in cycle E0+1.
- Each cycle memoryReady is low adds one cycle.
- All outputs are decoded from registered state and captured fields. There is no combinational path from req_* to memory_*.

## Structure
- Package lsu_pkg holds:
  - func3 constants: LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010.
  - The FSM state enum.
  - MEM_WORD_FUNC3 = 3'b010.
- One combinational sub-module, lsu_byte_lane, does load extraction/extension and store merge from (func3, offset, word, store data).

## Test plan
- LW addr 0x10 with memory word 0x80FF_1234 → resp_load_data 0x80FF_1234; resp_valid 2 cycles after accept.
- LB addr 0x13 on word 0x80FF_1234 → 0xFFFF_FF80. LBU addr 0x13 → 0x0000_0080. LHU addr 0x12 → 0x0000_80FF.
- SB 0xAB to addr 0x21 over existing word 0x1122_3344 → exactly one RD then one WR with data 0x1122_AB44; the read-back LW returns 0x1122_AB44.
- LW addr 0x06, and SH addr 0x05 → resp_misaligned = 1, no memory strobes, response 1 cycle after accept. Store with func3 100 → resp_misaligned = 1.
- memoryReady held low, TIMEOUT_CYCLES = 4, on a LW → exactly 4 RD cycles, then resp_timeout = 1, resp_load_data = 0. With memoryReady low for 2 cycles → normal completion 2 cycles late.
- Reset asserted during the RD of an SB → no WR, no resp_valid, req_ready = 1 the cycle after reset falls.
